// File: rtl/mult_sched_pkg.sv
// Shared types and default widths for the multiplier scheduler.
package mult_sched_pkg;

    localparam int DEF_NUM_REQ            = 4;
    localparam int DEF_MULTIPLICAND_WIDTH = 16;
    localparam int DEF_MULTIPLIER_WIDTH   = 8;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan requesters starting at ptr and take the first one found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_sched_shift_mult.sv
// Iterative shift-and-add unsigned multiplier. One multiplier bit is
// consumed per cycle and the run stops as soon as no set bits remain, so a
// multiplier whose highest set bit is k keeps busy high for k+1 cycles after
// the start cycle, and a zero multiplier never raises busy.
module shift_mult #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 8,
    localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [A_WIDTH-1:0] multiplicand,
    input  logic [B_WIDTH-1:0] multiplier,
    output logic               busy,
    output logic [P_WIDTH-1:0] product
);

    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [P_WIDTH-1:0] a_q, a_d;
    logic [B_WIDTH-1:0] b_q, b_d;
    logic               busy_q, busy_d;
    logic [B_WIDTH-1:0] b_shift;

    // Load operands on start, otherwise add-and-shift while busy.
    always_comb begin
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        b_shift = b_q >> 1;
        if (start) begin
            acc_d  = '0;
            a_d    = P_WIDTH'(multiplicand);
            b_d    = multiplier;
            busy_d = |multiplier;
        end else if (busy_q) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d    = a_q << 1;
            b_d    = b_shift;
            busy_d = |b_shift;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            busy_q <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign product = acc_q;

endmodule

// File: rtl/mult_sched.sv
// Shares one shift_mult between NUM_REQ requesters. A request is granted
// round-robin, its operands are latched, the multiplier is started and the
// result is returned to the owning requester on a shared product bus.
//
// Handshakes: a request transfers on a cycle where req_valid[i] and
// req_ready[i] are both high; requesters hold valid and operands until then.
// A response transfers on a cycle where rsp_valid[i] and rsp_ready[i] are
// both high; rsp_valid and rsp_product stay stable until that cycle.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ            = DEF_NUM_REQ,
    parameter int MULTIPLICAND_WIDTH = DEF_MULTIPLICAND_WIDTH,
    parameter int MULTIPLIER_WIDTH   = DEF_MULTIPLIER_WIDTH,
    localparam int PRODUCT_WIDTH     = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic [NUM_REQ-1:0][MULTIPLICAND_WIDTH-1:0]  req_multiplicand,
    input  logic [NUM_REQ-1:0][MULTIPLIER_WIDTH-1:0]    req_multiplier,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    input  logic [NUM_REQ-1:0]                          rsp_ready,
    output logic [PRODUCT_WIDTH-1:0]                    rsp_product,
    output logic                                        busy,
    output state_e                                      dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [MULTIPLICAND_WIDTH-1:0] a_q, a_d;
    logic [MULTIPLIER_WIDTH-1:0]   b_q, b_d;
    logic [PRODUCT_WIDTH-1:0]      prod_q, prod_d;

    logic [NUM_REQ-1:0]            arb_grant;
    logic [IDX_W-1:0]              arb_idx;
    logic                          arb_any;

    logic                          sm_start;
    logic                          sm_busy;
    logic [PRODUCT_WIDTH-1:0]      sm_product;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    shift_mult #(
        .A_WIDTH (MULTIPLICAND_WIDTH),
        .B_WIDTH (MULTIPLIER_WIDTH)
    ) u_mult (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (sm_start),
        .multiplicand (a_q),
        .multiplier   (b_q),
        .busy         (sm_busy),
        .product      (sm_product)
    );

    // Next-state logic: grant, launch, wait for the multiplier, hand back.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    idx_d   = arb_idx;
                    a_d     = req_multiplicand[arb_idx];
                    b_d     = req_multiplier[arb_idx];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (!sm_busy) begin
                    prod_d  = sm_product;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[idx_q]) begin
                    ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and operand/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    // Outputs decoded from registered state; req_ready is also held low
    // while reset is asserted so a requester waiting through reset is not
    // told it was accepted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE && rst_n) begin
            req_ready = arb_grant;
        end
        if (state_q == RESP) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign sm_start    = (state_q == LAUNCH);
    assign busy        = (state_q != IDLE);
    assign rsp_product = prod_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: scoreboard of expected products,
// owners and response cycles, plus a round-robin grant model.
module tb_mult_sched;
    import mult_sched_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int BW = 8;
    localparam int PW = AW + BW;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][AW-1:0]   req_multiplicand;
    logic [N-1:0][BW-1:0]   req_multiplier;
    logic [N-1:0]           rsp_valid;
    logic [N-1:0]           rsp_ready;
    logic [PW-1:0]          rsp_product;
    logic                   busy;
    state_e                 dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [PW-1:0] exp_q[$];
    int            idx_q[$];
    int            cyc_q[$];

    int            ptr_m = 0;
    logic [N-1:0]  acc_flag = '0;
    int            extra[N];
    logic          in_rsp = 1'b0;
    logic [PW-1:0] held_prod = '0;
    int            held_idx = 0;
    logic [PW-1:0] last_prod = '0;
    logic          rand_bp = 1'b0;

    mult_sched #(
        .NUM_REQ            (N),
        .MULTIPLICAND_WIDTH (AW),
        .MULTIPLIER_WIDTH   (BW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_multiplicand (req_multiplicand),
        .req_multiplier   (req_multiplier),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_product      (rsp_product),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int latency(input logic [BW-1:0] b);
        for (int i = BW - 1; i >= 0; i--) begin
            if (b[i]) return 4 + i;
        end
        return 3;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_multiplicand[i] = a;
        req_multiplier[i]   = b;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   n;
        logic ok;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (n < budget && !(exp_q.size() == 0 && !in_rsp && req_valid == '0 &&
                                   !busy && acc_flag == '0));
        ok = (n < budget);
        check_eq({"done_", tag}, 32'(ok), 32'd1);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_product", 32'(rsp_product), 32'd0);
        exp_q.delete();
        idx_q.delete();
        cyc_q.delete();
        in_rsp    = 1'b0;
        ptr_m     = 0;
        last_prod = '0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requester side: drop or reload a request once it has been accepted,
    // and apply random response backpressure when enabled.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                acc_flag[i] = 1'b0;
                if (extra[i] > 0) begin
                    extra[i]--;
                    req_multiplicand[i] = AW'($urandom_range(0, 65535));
                    req_multiplier[i]   = BW'($urandom_range(0, 255));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rand_bp) rsp_ready = N'($urandom_range(0, (1 << N) - 1));
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_vld;
        int           g;
        int           exp_c;
        if (rst_n) begin
            exp_grant = '0;
            if (!busy && req_valid != '0) begin
                g = rr_pick(req_valid, ptr_m);
                exp_grant[g] = 1'b1;
                check_eq("grant", 32'(req_ready), 32'(exp_grant));
                exp_q.push_back(PW'(req_multiplicand[g]) * PW'(req_multiplier[g]));
                idx_q.push_back(g);
                cyc_q.push_back(cyc + latency(req_multiplier[g]));
                acc_flag[g] = 1'b1;
            end else begin
                check_eq("ready_low", 32'(req_ready), 32'(exp_grant));
            end

            if (rsp_valid != '0 || in_rsp) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        held_prod = exp_q.pop_front();
                        held_idx  = idx_q.pop_front();
                        exp_c     = cyc_q.pop_front();
                        check_eq("rsp_latency", cyc, exp_c);
                        in_rsp = 1'b1;
                    end
                end
                if (in_rsp) begin
                    exp_vld = '0;
                    exp_vld[held_idx] = 1'b1;
                    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
                    check_eq("rsp_product", 32'(rsp_product), 32'(held_prod));
                    if (rsp_ready[held_idx]) begin
                        in_rsp    = 1'b0;
                        ptr_m     = (held_idx + 1) % N;
                        last_prod = held_prod;
                    end
                end
            end else begin
                check_eq("prod_hold", 32'(rsp_product), 32'(last_prod));
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Stimulus sequence.
    initial begin
        int   n;
        logic [N-1:0] mask;
        req_valid        = '0;
        req_multiplicand = '0;
        req_multiplier   = '0;
        rsp_ready        = '1;
        for (int i = 0; i < N; i++) extra[i] = 0;
        #2;
        apply_reset(3);

        // Directed single operations.
        @(posedge clk); #1; issue(0, 16'd3, 8'd5);
        wait_done("r0_3x5", 60);
        @(posedge clk); #1; issue(1, 16'hFFFF, 8'hFF);
        wait_done("r1_max", 60);
        @(posedge clk); #1; issue(2, 16'h1234, 8'h00);
        wait_done("r2_zero", 60);
        @(posedge clk); #1; issue(3, 16'h8001, 8'h80);
        wait_done("r3_msb", 60);

        // Held response with a competing request pending.
        @(posedge clk); #1; rsp_ready = 4'b1110; issue(0, 16'h0007, 8'h09);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (n < 40 && rsp_valid[0] !== 1'b1);
        check_eq("rsp0_seen", 32'(n < 40), 32'd1);
        @(posedge clk); #1; issue(1, 16'h00AA, 8'h11);
        repeat (4) @(posedge clk);
        #1 rsp_ready = '1;
        wait_done("hold0", 100);

        // All requesters from reset, requester 0 asks twice.
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_multiplicand[i] = AW'(16'h0100 + i);
            req_multiplier[i]   = BW'(8'h03 + i);
        end
        extra[0] = 1;
        @(posedge clk); #1;
        apply_reset(2);
        wait_done("all4", 200);

        // Random traffic with random response backpressure.
        rand_bp = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(posedge clk); #1;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) issue(i, AW'($urandom_range(0, 65535)), BW'($urandom_range(0, 255)));
            end
            wait_done("rand", 600);
        end
        rand_bp = 1'b0;
        @(posedge clk); #1; rsp_ready = '1;

        // Reset while the multiplier is running.
        @(posedge clk); #1; issue(3, 16'hABCD, 8'h80);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (n < 20 && dbg_state != RUN);
        check_eq("reached_run", 32'(n < 20), 32'd1);
        #1;
        apply_reset(2);
        repeat (20) @(posedge clk);
        #1; issue(3, 16'h0101, 8'h03);
        wait_done("after_rst", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
